// File: rtl/stream_fifo_if.sv
// Handshake bundle for stream_fifo. The master side is the producer/consumer
// pair that drives requests; the slave side is the FIFO itself.
//
// Request semantics (no ready/valid back-pressure loop): enq is a write
// request that is taken on a rising edge only when full is low, and
// deq is a read request that is taken only when empty is low. full and empty
// play the role of the ready signals. Both are decoded from the registered
// fill level, so a request never depends combinationally on the other one
// in the same cycle. A refused request is dropped. It sets the matching
// sticky error flag and is not retried.
interface stream_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             enq;
  logic [WIDTH-1:0] din;
  logic             deq;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;

  modport master (
    output enq, din, deq, clr_err,
    input  dout, full, empty, almost_full, almost_empty, level,
           overflow, underflow
  );

  modport slave (
    input  enq, din, deq, clr_err,
    output dout, full, empty, almost_full, almost_empty, level,
           overflow, underflow
  );
endinterface

// File: rtl/stream_fifo.sv
// Parametrised single-clock FIFO with arbitrary depth, optional
// first-word-fall-through read, fill level, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
module stream_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          reset,
  stream_fifo_if.slave  s
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full_w;
  logic             empty_w;
  logic             acc_wr;
  logic             acc_rd;

  // Status decodes from the registered level only.
  assign full_w  = (level_q == LW'(DEPTH));
  assign empty_w = (level_q == '0);

  // A request is accepted only against the current registered state, so a
  // write to a full FIFO is refused even if a read frees a slot this cycle.
  assign acc_wr = s.enq && !full_w;
  assign acc_rd = s.deq && !empty_w;

  // Next-state for pointers, level and error flags.
  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // Explicit wrap so that non-power-of-two depths work.
    if (acc_wr) begin
      wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
    end
    if (acc_rd) begin
      rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
    end

    case ({acc_wr, acc_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A fresh error event beats a coincident clear.
    if (s.enq && full_w) begin
      overflow_d = 1'b1;
    end else if (s.clr_err) begin
      overflow_d = 1'b0;
    end
    if (s.deq && empty_w) begin
      underflow_d = 1'b1;
    end else if (s.clr_err) begin
      underflow_d = 1'b0;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array, written only on an accepted write. Contents are not reset.
  // Reset makes the old words unreachable by clearing the pointers and level.
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      mem_q[wp_q] <= s.din;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is shown directly. The output reads zero while empty.
      assign s.dout = empty_w ? '0 : mem_q[rp_q];
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;

      // Registered read port that loads the head word on an accepted read
      // and holds its value otherwise.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout_q <= '0;
        end else if (acc_rd) begin
          dout_q <= mem_q[rp_q];
        end
      end

      assign s.dout = dout_q;
    end
  endgenerate

  assign s.full         = full_w;
  assign s.empty        = empty_w;
  assign s.almost_full  = (level_q >= LW'(AF_LEVEL));
  assign s.almost_empty = (level_q <= LW'(AE_LEVEL));
  assign s.level        = level_q;
  assign s.overflow     = overflow_q;
  assign s.underflow    = underflow_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo. Three instances cover three configurations:
//   u_a: DEPTH=5, FWFT=0 (AF=4, AE=1)
//   u_b: DEPTH=5, FWFT=1
//   u_c: DEPTH=8, FWFT=0, AF=6, AE=2
module tb_stream_fifo;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  stream_fifo_if #(.WIDTH(8), .DEPTH(5)) ifa ();
  stream_fifo_if #(.WIDTH(8), .DEPTH(5)) ifb ();
  stream_fifo_if #(.WIDTH(8), .DEPTH(8)) ifc ();

  stream_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_a (
    .clk(clk), .reset(reset), .s(ifa)
  );
  stream_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_b (
    .clk(clk), .reset(reset), .s(ifb)
  );
  stream_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_c (
    .clk(clk), .reset(reset), .s(ifc)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle on the selected instance. Outputs are sampled 1ns after the edge.
  task automatic step(input int sel, input logic e, input logic [7:0] d,
                      input logic q, input logic c);
    case (sel)
      0: begin ifa.enq = e; ifa.din = d; ifa.deq = q; ifa.clr_err = c; end
      1: begin ifb.enq = e; ifb.din = d; ifb.deq = q; ifb.clr_err = c; end
      default: begin ifc.enq = e; ifc.din = d; ifc.deq = q; ifc.clr_err = c; end
    endcase
    @(posedge clk);
    #1;
    ifa.enq = 1'b0; ifa.deq = 1'b0; ifa.clr_err = 1'b0;
    ifb.enq = 1'b0; ifb.deq = 1'b0; ifb.clr_err = 1'b0;
    ifc.enq = 1'b0; ifc.deq = 1'b0; ifc.clr_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    ifa.enq = 1'b0; ifa.din = '0; ifa.deq = 1'b0; ifa.clr_err = 1'b0;
    ifb.enq = 1'b0; ifb.din = '0; ifb.deq = 1'b0; ifb.clr_err = 1'b0;
    ifc.enq = 1'b0; ifc.din = '0; ifc.deq = 1'b0; ifc.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_empty",  32'(ifa.empty), 32'd1);
    check("rst_full",   32'(ifa.full), 32'd0);
    check("rst_ae",     32'(ifa.almost_empty), 32'd1);
    check("rst_af",     32'(ifa.almost_full), 32'd0);
    check("rst_level",  32'(ifa.level), 32'd0);
    check("rst_dout",   32'(ifa.dout), 32'd0);
    check("rst_ovf",    32'(ifa.overflow), 32'd0);
    check("rst_unf",    32'(ifa.underflow), 32'd0);
    reset = 1'b0;

    // Ordering, registered read
    step(0, 1'b1, 8'h11, 1'b0, 1'b0);
    check("ord_lvl1", 32'(ifa.level), 32'd1);
    check("ord_nempty", 32'(ifa.empty), 32'd0);
    step(0, 1'b1, 8'h22, 1'b0, 1'b0);
    step(0, 1'b1, 8'h33, 1'b0, 1'b0);
    check("ord_lvl3", 32'(ifa.level), 32'd3);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("ord_d0", 32'(ifa.dout), 32'h11);
    check("ord_lvl2", 32'(ifa.level), 32'd2);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("ord_d1", 32'(ifa.dout), 32'h22);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("ord_d2", 32'(ifa.dout), 32'h33);
    check("ord_lvl0", 32'(ifa.level), 32'd0);
    check("ord_empty", 32'(ifa.empty), 32'd1);
    step(0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("ord_hold", 32'(ifa.dout), 32'h33);

    // Wrap and full
    for (int i = 0; i < 5; i++) step(0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    check("wrap_full", 32'(ifa.full), 32'd1);
    check("wrap_lvl5", 32'(ifa.level), 32'd5);
    check("wrap_af", 32'(ifa.almost_full), 32'd1);
    step(0, 1'b1, 8'hFF, 1'b0, 1'b0);
    check("wrap_ovf", 32'(ifa.overflow), 32'd1);
    check("wrap_lvl_drop", 32'(ifa.level), 32'd5);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_rdA0", 32'(ifa.dout), 32'hA0);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_rdA1", 32'(ifa.dout), 32'hA1);
    step(0, 1'b1, 8'hB0, 1'b0, 1'b0);
    step(0, 1'b1, 8'hB1, 1'b0, 1'b0);
    check("wrap_lvl_refill", 32'(ifa.level), 32'd5);
    exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hB0, 8'hB1};
    while (exp_q.size() > 0) begin
      step(0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_order", 32'(ifa.dout), 32'(exp_q.pop_front()));
    end
    check("wrap_empty", 32'(ifa.empty), 32'd1);

    // Simultaneous operations
    step(0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", 32'(ifa.overflow), 32'd0);
    step(0, 1'b1, 8'h41, 1'b1, 1'b0);
    check("sim_empty_lvl", 32'(ifa.level), 32'd1);
    check("sim_empty_unf", 32'(ifa.underflow), 32'd1);
    check("sim_empty_dout", 32'(ifa.dout), 32'hB1);
    step(0, 1'b1, 8'h42, 1'b0, 1'b0);
    step(0, 1'b1, 8'h43, 1'b1, 1'b0);
    check("sim_mid_lvl", 32'(ifa.level), 32'd2);
    check("sim_mid_d", 32'(ifa.dout), 32'h41);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("sim_mid_d2", 32'(ifa.dout), 32'h42);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("sim_mid_d3", 32'(ifa.dout), 32'h43);
    for (int i = 0; i < 5; i++) step(0, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    step(0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("sim_full_pre_ovf", 32'(ifa.overflow), 32'd0);
    step(0, 1'b1, 8'h99, 1'b1, 1'b0);
    check("sim_full_lvl", 32'(ifa.level), 32'd4);
    check("sim_full_ovf", 32'(ifa.overflow), 32'd1);
    check("sim_full_d", 32'(ifa.dout), 32'h50);
    exp_q = '{8'h51, 8'h52, 8'h53, 8'h54};
    while (exp_q.size() > 0) begin
      step(0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("sim_full_order", 32'(ifa.dout), 32'(exp_q.pop_front()));
    end
    check("sim_full_empty", 32'(ifa.empty), 32'd1);

    // FWFT instance
    check("fw_rst_dout", 32'(ifb.dout), 32'd0);
    step(1, 1'b1, 8'h5A, 1'b0, 1'b0);
    check("fw_dout", 32'(ifb.dout), 32'h5A);
    check("fw_nempty", 32'(ifb.empty), 32'd0);
    step(1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("fw_hold", 32'(ifb.dout), 32'h5A);
    step(1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("fw_deq_dout", 32'(ifb.dout), 32'd0);
    check("fw_deq_empty", 32'(ifb.empty), 32'd1);
    step(1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("fw_unf", 32'(ifb.underflow), 32'd1);
    check("fw_unf_lvl", 32'(ifb.level), 32'd0);
    step(1, 1'b1, 8'h61, 1'b0, 1'b0);
    step(1, 1'b1, 8'h62, 1'b0, 1'b0);
    check("fw_head", 32'(ifb.dout), 32'h61);
    step(1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("fw_next", 32'(ifb.dout), 32'h62);

    // Thresholds on DEPTH=8, AF=6, AE=2
    check("thr_ae_l0", 32'(ifc.almost_empty), 32'd1);
    check("thr_af_l0", 32'(ifc.almost_full), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step(2, 1'b1, 8'(i), 1'b0, 1'b0);
      check("thr_lvl", 32'(ifc.level), 32'(i));
      check("thr_ae", 32'(ifc.almost_empty), 32'(i <= 2));
      check("thr_af", 32'(ifc.almost_full), 32'(i >= 6));
    end
    check("thr_full", 32'(ifc.full), 32'd1);
    step(2, 1'b1, 8'hEE, 1'b0, 1'b1);
    check("thr_clr_vs_set", 32'(ifc.overflow), 32'd1);
    step(2, 1'b0, 8'h00, 1'b0, 1'b1);
    check("thr_clr", 32'(ifc.overflow), 32'd0);

    // Asynchronous reset in the middle of a transfer
    for (int i = 0; i < 4; i++) step(0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check("ar_pre_lvl", 32'(ifa.level), 32'd4);
    ifa.enq = 1'b1;
    ifa.din = 8'h64;
    #2;
    reset = 1'b1;
    #1;
    check("ar_lvl", 32'(ifa.level), 32'd0);
    check("ar_empty", 32'(ifa.empty), 32'd1);
    check("ar_full", 32'(ifa.full), 32'd0);
    check("ar_ae", 32'(ifa.almost_empty), 32'd1);
    check("ar_af", 32'(ifa.almost_full), 32'd0);
    check("ar_dout", 32'(ifa.dout), 32'd0);
    check("ar_ovf", 32'(ifa.overflow), 32'd0);
    ifa.enq = 1'b0;
    reset = 1'b0;
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("ar_unf", 32'(ifa.underflow), 32'd1);
    check("ar_unf_lvl", 32'(ifa.level), 32'd0);
    step(0, 1'b1, 8'h70, 1'b0, 1'b0);
    check("ar_enq_lvl", 32'(ifa.level), 32'd1);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("ar_deq_d", 32'(ifa.dout), 32'h70);
    check("ar_deq_empty", 32'(ifa.empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous FIFO, successor to the basic byte queue used between the UART/sensor front ends and the focus-timer logic. Adds arbitrary (non-power-of-two) depth, a selectable first-word-fall-through (FWFT) read mode, a fill-level output, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Single clock domain; sits between any producer/consumer pair in the fabric.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 64, storage words; any integer >=2, power of two not required
- FWFT, 0, 0 = registered read (dout updates on deq); 1 = first-word-fall-through
- AF_LEVEL, DEPTH-1, almost_full asserts when level >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when level <= AE_LEVEL (0..DEPTH-1)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enq  in  1  write request
- din  in  WIDTH  write data, sampled when enq accepted
- deq  in  1  read request / head acknowledge
- clr_err  in  1  synchronous clear of overflow/underflow
- dout  out  WIDTH  read data
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- level  out  $clog2(DEPTH+1)  current stored word count, 0..DEPTH
- overflow  out  1  sticky: enq attempted while full
- underflow  out  1  sticky: deq attempted while empty

## Operation
- Circular buffer mem[0..DEPTH-1], write pointer wp, read pointer rp, counter level.
- Pointer wrap explicit: ptr <= (ptr == DEPTH-1) ? 0 : ptr+1. No reliance on natural binary overflow.
- Accepted write: enq && !full -> mem[wp] <= din, wp advances.
- Accepted read: deq && !empty -> rp advances.
- level <= level + acc_wr - acc_rd; simultaneous accepted write and read leave level unchanged.
- full/empty evaluated on the current registered level: enq while full is dropped even if deq is asserted the same cycle; deq while empty is ignored even if enq is asserted the same cycle (that enq is accepted).
- FWFT=0: dout is a register; on accepted read dout <= mem[rp]; otherwise holds its value (including while empty).
- FWFT=1: dout = empty ? 0 : mem[rp] (combinational from registered state); deq consumes the displayed word.
- almost_full/almost_empty/full/empty: combinational decodes of registered level.
- overflow sets on enq && full; underflow sets on deq && empty; both held until clr_err or reset. If clr_err coincides with a new error event, the set wins.
- Rejected operations never change mem, pointers or level.

## Timing
- Reset (async assert, any time including mid-transfer): wp=rp=0, level=0, dout=0, overflow=underflow=0; thus empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>=1). Stored data discarded.
- Write latency: enq accepted at edge N -> level, empty, almost_* update after edge N.
- FWFT=0 read latency: deq accepted at edge N -> dout valid after edge N (one cycle).
- FWFT=1: word written into empty FIFO at edge N appears on dout after edge N, together with empty deasserting; after an accepted read at edge N, dout shows the next word (or 0 if now empty) after edge N.
- Error flags assert the cycle after the offending request.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset/ordering, WIDTH=8, DEPTH=5, FWFT=0: reset, enq 0x11,0x22,0x33, then deq x3 -> dout 0x11,0x22,0x33 each one cycle after its deq; level 3->0; empty=1 at end; dout holds 0x33.
- Wrap and full, DEPTH=5: write 5 words (0xA0..0xA4) -> full=1, level=5; 6th enq (0xFF) dropped, overflow=1; deq 2, enq 0xB0,0xB1 (pointers wrap past 4) -> read-out order 0xA2,0xA3,0xA4,0xB0,0xB1.
- FWFT=1: enq 0x5A into empty -> next cycle dout=0x5A, empty=0 without deq; deq -> dout=0, empty=1; deq while empty -> underflow=1, level stays 0.
- Simultaneous ops: level=2, enq+deq same cycle -> level stays 2, data order preserved; at empty, enq+deq -> enq accepted, level=1, underflow=1; at full, enq+deq -> read accepted, write dropped, level=DEPTH-1, overflow=1.
- Thresholds, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2: fill 0->8 -> almost_empty=1 at levels 0..2, almost_full=1 at levels 6..8; clr_err with simultaneous overflow event -> overflow remains 1; clr_err alone -> 0.
- Async reset mid-operation: level=4 with enq active, assert reset between edges -> all outputs immediately return to reset values; after release, first deq is ignored (underflow=1) and subsequent enq/deq behave from empty.
